dm_access_unit: RTL and testbench

Initiator for the data-memory cache port. Takes single-word load/store requests from the core's memory stage and drives the cache request interface: `rd_en_dm`/`wr_en_dm`, address and write data. It holds the pipeline stalled until the cache returns `done`, then extracts the addressed 32-bit word from the returned 128-bit line. It sits between the MEM stage and `Data_memory_cache`.

---
 rtl/dm_access_unit.sv | 105 ++++++++++
 tb/tb_dm_access_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// Data-memory access initiator: turns MEM-stage load/store requests into cache port requests.
// Optional completion watchdog is compiled in with `define DM_TIMEOUT_EN.
module dm_access_unit #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              rd_en_dm,
    output logic              wr_en_dm,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_data_in,
    input  logic [127:0]      dm_data_out,
    input  logic              dm_done
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t     state;
    logic       request;
    logic       wd_expire;
    logic [6:0] word_ofs;

    assign request  = mem_read | mem_write;
    assign stall    = (state == REQ) || ((state == IDLE) && request);
    assign word_ofs = {dm_address[3:2], 5'b00000};

`ifdef DM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;

    // Counter holds the number of REQ cycles already spent; expiry on the TIMEOUT-th one.
    assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == REQ)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if ((state == REQ) && !dm_done && wd_expire)
                err <= 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_en_dm    <= 1'b0;
            wr_en_dm    <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            dm_address  <= '0;
            dm_data_in  <= '0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A simultaneous read and write is treated as a store only.
                    if (request) begin
                        state      <= REQ;
                        dm_address <= addr;
                        dm_data_in <= wdata;
                        wr_en_dm   <= mem_write;
                        rd_en_dm   <= ~mem_write;
                    end
                end
                REQ: begin
                    if (dm_done) begin
                        state    <= RESP;
                        rd_en_dm <= 1'b0;
                        wr_en_dm <= 1'b0;
                        if (rd_en_dm) begin
                            rdata       <= dm_data_out[word_ofs +: 32];
                            rdata_valid <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        state    <= RESP;
                        rd_en_dm <= 1'b0;
                        wr_en_dm <= 1'b0;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: a timeline model of each access predicts every
// output on every cycle, and the bench also plays the cache, answering after a chosen delay.
module tb_dm_access_unit;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              stall;
    logic [31:0]       rdata;
    logic              rdata_valid;
    logic              err;
    logic              rd_en_dm, wr_en_dm;
    logic [ADDR_W-1:0] dm_address;
    logic [31:0]       dm_data_in;
    logic [127:0]      dm_data_out;
    logic              dm_done;

    dm_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
        .rdata_valid(rdata_valid), .err(err), .rd_en_dm(rd_en_dm),
        .wr_en_dm(wr_en_dm), .dm_address(dm_address), .dm_data_in(dm_data_in),
        .dm_data_out(dm_data_out), .dm_done(dm_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int compared   = 0;
    int mismatched = 0;

    // Model of the access currently in flight: start cycle and completion delay.
    bit                m_active = 0;
    int                m_s = 0, m_n = 0;
    bit                m_wr = 0, m_timeout = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [31:0]       m_wdata = '0;
    int                idle_from = 0;
    logic [31:0]       exp_rdata = '0;
    bit                exp_err = 0;
    int                done_delay = 1;
    bit                spurious_done = 0;

    int cnt_stall, cnt_wr, cnt_rd, cnt_valid, last_valid, valid_gap;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle prediction, sampled mid-cycle away from the rising edge.
    always @(negedge clk) begin
        bit                e_rd, e_wr, e_val, e_stall, req;
        logic [ADDR_W-1:0] e_addr;
        logic [31:0]       e_wd;
        logic [127:0]      line_sh;
        req = mem_read | mem_write;
        e_rd = 0; e_wr = 0; e_val = 0; e_stall = 0;
        if (rst) begin
            m_active  = 0;
            idle_from = 0;
            exp_rdata = '0;
            exp_err   = 0;
            m_addr    = '0;
            m_wdata   = '0;
            e_stall   = req;
            e_addr    = '0;
            e_wd      = '0;
        end else begin
            e_addr = m_addr;
            e_wd   = m_wdata;
            if (m_active && cyc >= m_s + 1 && cyc <= m_s + m_n) begin
                e_stall = 1;
                e_rd    = !m_wr;
                e_wr    = m_wr;
            end else if (m_active && cyc == m_s + m_n + 1) begin
                e_val = !m_wr && !m_timeout;
                if (e_val) begin
                    line_sh   = dm_data_out >> (m_addr[3:2] * 32);
                    exp_rdata = line_sh[31:0];
                end
                if (m_timeout) exp_err = 1;
                m_active  = 0;
                idle_from = cyc + 1;
            end else begin
                e_stall = req;
                if (req && cyc >= idle_from) begin
                    m_active = 1;
                    m_s      = cyc;
                    m_wr     = mem_write;
                    m_addr   = addr;
                    m_wdata  = wdata;
`ifdef DM_TIMEOUT_EN
                    m_timeout = (done_delay > TIMEOUT);
                    m_n       = m_timeout ? TIMEOUT : done_delay;
`else
                    m_timeout = 0;
                    m_n       = done_delay;
`endif
                end
            end
        end
        checkOutput("stall", 32'(stall), 32'(e_stall));
        checkOutput("rd_en_dm", 32'(rd_en_dm), 32'(e_rd));
        checkOutput("wr_en_dm", 32'(wr_en_dm), 32'(e_wr));
        checkOutput("rdata_valid", 32'(rdata_valid), 32'(e_val));
        checkOutput("rdata", rdata, exp_rdata);
        checkOutput("err", 32'(err), 32'(exp_err));
        checkOutput("dm_address", 32'(dm_address), 32'(e_addr));
        checkOutput("dm_data_in", dm_data_in, e_wd);
        // The cache answers in the N-th enable cycle; stray completions only outside accesses.
        dm_done = (m_active && !m_timeout && cyc == m_s + m_n) || (!m_active && spurious_done);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (stall)    cnt_stall++;
            if (wr_en_dm) cnt_wr++;
            if (rd_en_dm) cnt_rd++;
            if (rdata_valid) begin
                if (last_valid >= 0) valid_gap = cyc - last_valid;
                last_valid = cyc;
                cnt_valid++;
            end
        end
    end

    task automatic clearCounters();
        cnt_stall = 0; cnt_wr = 0; cnt_rd = 0; cnt_valid = 0;
        last_valid = -1; valid_gap = 0;
    endtask

    task automatic waitIdle(input string name);
        int k;
        k = 0;
        while (m_active && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (m_active) checkOutput({name, "_timeout"}, 32'(m_active), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Present one request and hold it only until the unit has taken it.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                                 input logic [31:0] d, input int n, input string name);
        int k;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; addr = a; wdata = d; done_delay = n;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!m_active && k < 50);
        if (!m_active) checkOutput({name, "_accept"}, 32'(m_active), 32'd1);
        mem_read = 0; mem_write = 0;
        waitIdle(name);
    endtask

    initial begin
        rst = 1; mem_read = 0; mem_write = 0; addr = '0; wdata = '0;
        dm_data_out = '0; dm_done = 0;
        clearCounters();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rd_en", 32'(rd_en_dm), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        rst = 0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] store with 3-cycle cache latency");
        clearCounters();
        applyStimulus(0, 1, 10'h000, 32'hAABBCCDD, 3, "store");
        checkOutput("store_wr_cycles", 32'(cnt_wr), 32'd3);
        checkOutput("store_stall_cycles", 32'(cnt_stall), 32'd4);
        checkOutput("store_no_valid", 32'(cnt_valid), 32'd0);

        $display("[TB] loads selecting words 2 and 3");
        dm_data_out = 128'h44444444_33333333_22222222_11111111;
        clearCounters();
        applyStimulus(1, 0, 10'h008, 32'h0, 2, "load8");
        checkOutput("load8_rdata", rdata, 32'h33333333);
        checkOutput("load8_valid_cnt", 32'(cnt_valid), 32'd1);
        applyStimulus(1, 0, 10'h00C, 32'h0, 1, "loadC");
        checkOutput("loadC_rdata", rdata, 32'h44444444);

        $display("[TB] read and write together");
        clearCounters();
        applyStimulus(1, 1, 10'h004, 32'h12345678, 2, "both");
        checkOutput("both_wr_cycles", 32'(cnt_wr), 32'd2);
        checkOutput("both_rd_cycles", 32'(cnt_rd), 32'd0);
        checkOutput("both_no_valid", 32'(cnt_valid), 32'd0);
        checkOutput("both_rdata_held", rdata, 32'h44444444);

        $display("[TB] stray completion while idle, then low words");
        spurious_done = 1;
        repeat (3) @(posedge clk);
        #1;
        spurious_done = 0;
        applyStimulus(1, 0, 10'h000, 32'h0, 5, "load0");
        checkOutput("load0_rdata", rdata, 32'h11111111);
        applyStimulus(1, 0, 10'h007, 32'h0, 1, "load7");
        checkOutput("load7_rdata", rdata, 32'h22222222);

        $display("[TB] back-to-back loads with immediate completion");
        clearCounters();
        @(posedge clk); #1;
        mem_read = 1; addr = 10'h00C; done_delay = 1;
        repeat (9) @(posedge clk);
        #1;
        mem_read = 0;
        waitIdle("b2b");
        checkOutput("b2b_valid_cnt", 32'(cnt_valid), 32'd3);
        checkOutput("b2b_valid_gap", 32'(valid_gap), 32'd3);

        $display("[TB] reset during an outstanding load");
        clearCounters();
        @(posedge clk); #1;
        mem_read = 1; addr = 10'h008; done_delay = 50;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        #1;
        checkOutput("rst_rd_en_drop", 32'(rd_en_dm), 32'd0);
        checkOutput("rst_stall_req", 32'(stall), 32'd1);
        @(posedge clk); #1;
        mem_read = 0;
        #1;
        checkOutput("rst_stall_drop", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        checkOutput("rst_no_valid", 32'(cnt_valid), 32'd0);
        applyStimulus(1, 0, 10'h008, 32'h0, 2, "post_rst");
        checkOutput("post_rst_rdata", rdata, 32'h33333333);

`ifdef DM_TIMEOUT_EN
        $display("[TB] cache never completes");
        clearCounters();
        applyStimulus(1, 0, 10'h004, 32'h0, 1000, "wdog");
        checkOutput("wdog_rd_cycles", 32'(cnt_rd), 32'd8);
        checkOutput("wdog_err", 32'(err), 32'd1);
        checkOutput("wdog_no_valid", 32'(cnt_valid), 32'd0);
`else
        checkOutput("err_tied_low", 32'(err), 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
